noise_gate: RTL and testbench
=============================

Name: noise_gate

Overview:
- Per-sample noise gate with hysteresis, hold timer and ramped gain; sits directly upstream of the heavy-metal distortion stage.
- Mutes low-level hiss and hum before the distortion stage's pre-gain amplifies them.
- Uses the same sample_strobe / signed-sample / enable-bypass conventions as the other FX stages, so it chains directly into the distortion input.

Parameters:
- DATA_WIDTH, 32: signed sample width.
- ENV_SHIFT, 6: envelope decay; per strobe, decay is env >> ENV_SHIFT.
- OPEN_THRESH, 32'h0100_0000: envelope level at or above which the gate opens; unsigned, DATA_WIDTH-1 bits.
- CLOSE_THRESH, 32'h0080_0000: envelope level below which the gate starts closing. Must be <= OPEN_THRESH.
- HOLD_SAMPLES, 2400: strobes the gate stays at unity after the envelope falls below CLOSE_THRESH. Must be >= 1.
- GAIN_BITS, 8: gain fraction bits; UNITY = 2^GAIN_BITS.
- ATTACK_STEP, 16: gain increment per strobe in ATTACK.
- RELEASE_STEP, 1: gain decrement per strobe in RELEASE.

Ports:
- clk  in  1: clock.
- rst_n  in  1: reset, asynchronous, active-low.
- enable  in  1: 1 = gate active; 0 = bypass.
- sample_strobe  in  1: one-cycle pulse; all state advances only on cycles where it is high.
- sample_in  in  DATA_WIDTH: signed input sample.
- sample_out  out  DATA_WIDTH: signed gated sample, registered.
- gate_open  out  1: registered; 1 when state != CLOSED.

Behaviour:
- Reset (async): sample_out=0, gate_open=0, state=CLOSED, gain=0, env=0, hold_cnt=0.
- No strobe: all registers hold their values.
- Latency: sample_out reflects the sample_in presented at the same strobe, visible on the cycle after the strobe.

Per strobe, enable=1, evaluated in this order:
1. abs = |sample_in|; the most negative input maps to 2^(DATA_WIDTH-1)-1.
2. env_n:
   - if abs > env: env_n = abs (instant attack);
   - else: env_n = env - (env >> ENV_SHIFT).
   - env_n is stored as env.
3. gain_n, computed from the current state and current gain:
   - CLOSED: 0
   - ATTACK: min(gain+ATTACK_STEP, UNITY)
   - OPEN: UNITY
   - HOLD: UNITY
   - RELEASE: max(gain-RELEASE_STEP, 0)
   - gain register is GAIN_BITS+1 bits, unsigned.
4. Transitions, using env_n and gain_n; first match wins:
   - CLOSED: env_n >= OPEN_THRESH -> ATTACK.
   - ATTACK: gain_n == UNITY -> OPEN.
   - OPEN: env_n < CLOSE_THRESH -> HOLD, load hold_cnt = HOLD_SAMPLES-1.
   - HOLD: env_n >= OPEN_THRESH -> OPEN; else hold_cnt == 0 -> RELEASE; else hold_cnt decrements. HOLD therefore lasts exactly HOLD_SAMPLES strobes.
   - RELEASE: env_n >= OPEN_THRESH -> ATTACK (ramp resumes from the current gain); else gain_n == 0 -> CLOSED.
5. Output: sample_out = (sample_in * gain_n) >>> GAIN_BITS.
   - Full-width signed product; arithmetic shift, floor toward -inf.
   - Gain is never above unity, so no saturation is needed.
   - gain_n == UNITY gives sample_out == sample_in exactly.
6. gate_open = (next state != CLOSED).

Per strobe, enable=0:
- sample_out <= sample_in.
- env still tracks per step 2.
- state forced to OPEN, gain = UNITY, hold_cnt = 0, gate_open = 1.
- On re-enable, the gate starts in OPEN with no click.

Other rules:
- enable is sampled only on strobes.
- Reset mid-ramp returns immediately to the reset values.

Test Plan:
Bench parameters: ENV_SHIFT=2, OPEN_THRESH=1000, CLOSE_THRESH=500, HOLD_SAMPLES=4, GAIN_BITS=4, ATTACK_STEP=4, RELEASE_STEP=2.

1. Reset, then strobes with sample_in=100:
   - sample_out=0, gate_open=0, state stays CLOSED.
2. From CLOSED, strobes with sample_in=2000:
   - sample_out = 0, 500, 1000, 1500, 2000, 2000 ...
   - gate_open=1 from the first strobe; OPEN reached at the 5th strobe.
3. After step 2, strobes with sample_in=0:
   - env = 1500, 1125, 844, 633, 475.
   - HOLD entered at the 5th strobe; RELEASE after 4 further strobes.
   - Gain then falls 14, 12 ... 0 over 8 strobes; CLOSED reached, gate_open=0.
4. During RELEASE at gain=10, one strobe with sample_in=-3000:
   - state -> ATTACK; sample_out = (-3000*8)>>>4 = -1500.
   - Next strobe with 0 input: gain=12.
5. In OPEN, sample_in=-2^31:
   - sample_out = -2^31.
   - env = 2^31-1 (abs saturated).
6. enable=0, sample_in=7:
   - sample_out=7, gate_open=1.
   - Re-enable with 2000: output 2000 immediately.
   - Assert rst_n low mid-ATTACK: all outputs 0 asynchronously.

Source files
------------

// File: rtl/noise_gate.sv
// rtl/noise_gate.sv - per-sample noise gate with hysteresis, hold timer and ramped gain
//
// Mutes low-level hiss and hum ahead of the distortion stage. A peak envelope
// (instant attack, exponential decay) drives a CLOSED/ATTACK/OPEN/HOLD/RELEASE
// FSM whose gain ramps the output in and out to avoid clicks.
//
// Ports:
//   clk           clock
//   rst_n         asynchronous active-low reset
//   enable        1 = gate active, 0 = bypass (sampled only on strobes)
//   sample_strobe one-cycle pulse; state advances only when high
//   sample_in     signed input sample
//   sample_out    signed gated sample, registered
//   gate_open     registered, 1 whenever the FSM is not CLOSED
module noise_gate #(
  parameter int          DATA_WIDTH   = 32,
  parameter int          ENV_SHIFT    = 6,
  parameter int unsigned OPEN_THRESH  = 32'h0100_0000,
  parameter int unsigned CLOSE_THRESH = 32'h0080_0000,
  parameter int          HOLD_SAMPLES = 2400,
  parameter int          GAIN_BITS    = 8,
  parameter int          ATTACK_STEP  = 16,
  parameter int          RELEASE_STEP = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         sample_strobe,
  input  logic signed [DATA_WIDTH-1:0] sample_in,
  output logic signed [DATA_WIDTH-1:0] sample_out,
  output logic                         gate_open
);

  localparam int EW = DATA_WIDTH - 1;
  localparam int GW = GAIN_BITS + 1;
  localparam int HW = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;
  localparam int PW = DATA_WIDTH + GW;

  localparam logic [EW-1:0] OPEN_T    = EW'(OPEN_THRESH);
  localparam logic [EW-1:0] CLOSE_T   = EW'(CLOSE_THRESH);
  localparam logic [GW-1:0] UNITY     = {1'b1, {GAIN_BITS{1'b0}}};
  localparam logic [GW-1:0] ATK       = GW'(ATTACK_STEP);
  localparam logic [GW-1:0] REL       = GW'(RELEASE_STEP);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_SAMPLES - 1);

  typedef enum logic [2:0] {
    CLOSED  = 3'd0,
    ATTACK  = 3'd1,
    OPEN    = 3'd2,
    HOLD    = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [EW-1:0]           env_q, env_d;
  logic [GW-1:0]           gain_q, gain_d;
  logic [HW-1:0]           hold_q, hold_d;
  logic signed [DATA_WIDTH-1:0] out_d;

  logic [DATA_WIDTH-1:0]   neg;
  logic [EW-1:0]           abs_s;
  logic [GW:0]             atk_sum;
  logic signed [PW-1:0]    prod;

  always_comb begin
    // Magnitude; the most negative code has no positive twin, so saturate it.
    neg = DATA_WIDTH'(-sample_in);
    if (!sample_in[DATA_WIDTH-1])
      abs_s = EW'(sample_in);
    else if (sample_in[DATA_WIDTH-2:0] == '0)
      abs_s = '1;
    else
      abs_s = EW'(neg);

    env_d = (abs_s > env_q) ? abs_s : env_q - (env_q >> ENV_SHIFT);

    atk_sum = {1'b0, gain_q} + {1'b0, ATK};
    case (state_q)
      ATTACK:  gain_d = (atk_sum >= {1'b0, UNITY}) ? UNITY : atk_sum[GW-1:0];
      OPEN,
      HOLD:    gain_d = UNITY;
      RELEASE: gain_d = (gain_q <= REL) ? '0 : gain_q - REL;
      default: gain_d = '0;
    endcase

    // Transitions look at the freshly computed envelope and gain.
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      CLOSED:  if (env_d >= OPEN_T) state_d = ATTACK;
      ATTACK:  if (gain_d == UNITY) state_d = OPEN;
      OPEN: begin
        if (env_d < CLOSE_T) begin
          state_d = HOLD;
          hold_d  = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (env_d >= OPEN_T)    state_d = OPEN;
        else if (hold_q == '0)  state_d = RELEASE;
        else                    hold_d  = hold_q - 1'b1;
      end
      RELEASE: begin
        if (env_d >= OPEN_T)    state_d = ATTACK;
        else if (gain_d == '0)  state_d = CLOSED;
      end
      default: state_d = CLOSED;
    endcase

    // Bypass parks the gate fully open so re-enabling cannot click.
    if (!enable) begin
      state_d = OPEN;
      gain_d  = UNITY;
      hold_d  = '0;
    end

    // Gain is unsigned; the zero-extended operand keeps the multiply signed.
    prod  = sample_in * $signed({1'b0, gain_d});
    out_d = DATA_WIDTH'(prod >>> GAIN_BITS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLOSED;
      env_q      <= '0;
      gain_q     <= '0;
      hold_q     <= '0;
      sample_out <= '0;
      gate_open  <= 1'b0;
    end else if (sample_strobe) begin
      state_q    <= state_d;
      env_q      <= env_d;
      gain_q     <= gain_d;
      hold_q     <= hold_d;
      sample_out <= out_d;
      gate_open  <= (state_d != CLOSED);
    end
  end

endmodule

// File: tb/tb_noise_gate.sv
// tb/tb_noise_gate.sv - scoreboard testbench for noise_gate
module tb_noise_gate;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               enable = 1'b0;
  logic               sample_strobe = 1'b0;
  logic signed [31:0] sample_in = '0;
  logic signed [31:0] sample_out;
  logic               gate_open;

  int n_checks = 0;
  int n_fail   = 0;

  logic signed [31:0] exp_out_q[$];
  logic               exp_open_q[$];
  string              exp_name_q[$];

  int exp_ramp[7] = '{0, 500, 1000, 1500, 2000, 2000, 2000};

  noise_gate #(
    .DATA_WIDTH  (32),
    .ENV_SHIFT   (2),
    .OPEN_THRESH (1000),
    .CLOSE_THRESH(500),
    .HOLD_SAMPLES(4),
    .GAIN_BITS   (4),
    .ATTACK_STEP (4),
    .RELEASE_STEP(2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .sample_strobe(sample_strobe),
    .sample_in    (sample_in),
    .sample_out   (sample_out),
    .gate_open    (gate_open)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  task automatic strobe(input logic signed [31:0] s, input logic en,
                        input logic signed [31:0] eo, input logic eg, input string name);
    @(negedge clk);
    sample_in     = s;
    enable        = en;
    sample_strobe = 1'b1;
    exp_out_q.push_back(eo);
    exp_open_q.push_back(eg);
    exp_name_q.push_back(name);
    @(negedge clk);
    sample_strobe = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && exp_out_q.size() != 0; k++) @(negedge clk);
    n_checks++;
    if (exp_out_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected responses never observed", exp_out_q.size());
      exp_out_q.delete();
      exp_open_q.delete();
      exp_name_q.delete();
    end
  endtask

  // Monitor: every strobe accepted at a rising edge yields one response,
  // checked on the following falling edge.
  initial begin
    forever begin
      @(posedge clk);
      if (rst_n && sample_strobe) begin
        @(negedge clk);
        if (exp_out_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected: got %0d expected no response", sample_out);
        end else begin
          logic signed [31:0] eo;
          logic               eg;
          string              nm;
          eo = exp_out_q.pop_front();
          eg = exp_open_q.pop_front();
          nm = exp_name_q.pop_front();
          check({nm, " out"}, sample_out, eo);
          check({nm, " open"}, {31'b0, gate_open}, {31'b0, eg});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check("reset out", sample_out, 32'sd0);
    check("reset open", {31'b0, gate_open}, 32'd0);
    rst_n  = 1'b1;
    enable = 1'b1;

    // Quiet input never opens the gate.
    for (int i = 0; i < 4; i++) strobe(100, 1'b1, 0, 1'b0, "quiet");

    // Loud input ramps up by 4/16 per strobe; odd count leaves env at 2000.
    for (int i = 0; i < 7; i++) strobe(2000, 1'b1, exp_ramp[i], 1'b1, "attack");

    // Without a strobe nothing moves, even when the input changes.
    @(negedge clk);
    sample_in = -5;
    repeat (3) @(negedge clk);
    check("no strobe out", sample_out, 32'sd2000);
    check("no strobe open", {31'b0, gate_open}, 32'd1);

    // Input 16 makes sample_out equal the gain, without disturbing the envelope
    // (16 stays below the decaying envelope). HOLD at 5th, RELEASE at 9th.
    for (int i = 0; i < 17; i++)
      strobe(16, 1'b1, (i < 9) ? 16 : 16 - 2 * (i - 8), (i < 16), "release");

    // Reopen, fall back into RELEASE, then retrigger at gain 10.
    for (int i = 0; i < 5; i++) strobe(2000, 1'b1, exp_ramp[i], 1'b1, "reopen");
    for (int i = 0; i < 12; i++)
      strobe(16, 1'b1, (i < 9) ? 16 : 16 - 2 * (i - 8), 1'b1, "rerelease");
    strobe(-3000, 1'b1, -1500, 1'b1, "retrigger");
    strobe(16, 1'b1, 12, 1'b1, "resume");
    strobe(16, 1'b1, 16, 1'b1, "reopened");

    // Most negative sample passes unchanged at unity; envelope saturates.
    strobe(32'sh8000_0000, 1'b1, 32'sh8000_0000, 1'b1, "min sample");
    drain();
    check("env saturated", {1'b0, dut.env_q}, 32'h7fff_ffff);

    // Bypass, then re-enable straight into OPEN.
    strobe(7, 1'b0, 7, 1'b1, "bypass");
    strobe(2000, 1'b1, 2000, 1'b1, "reenable");
    drain();

    // Fresh start, get into ATTACK, then reset asynchronously mid-cycle.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    strobe(2000, 1'b1, 0, 1'b1, "trigger");
    strobe(2000, 1'b1, 500, 1'b1, "ramp");
    drain();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset out", sample_out, 32'sd0);
    check("async reset open", {31'b0, gate_open}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
